// File: rtl/ycbcr_to_rgb_pipe_if.sv
// Pixel stream bundle for the YCbCr-to-RGB converter.
// slave: converter side; master: producer/consumer side.
interface ycbcr_to_rgb_pipe_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
);
  logic              mode;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] y_in;
  logic [DATA_W-1:0] cb_in;
  logic [DATA_W-1:0] cr_in;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] r_out;
  logic [DATA_W-1:0] g_out;
  logic [DATA_W-1:0] b_out;
  logic [CNT_W-1:0]  sat_cnt;
  logic              sat_clr;

  modport slave (
    input  mode, in_valid, y_in, cb_in, cr_in,
    input  out_ready, sat_clr,
    output in_ready, out_valid,
    output r_out, g_out, b_out, sat_cnt
  );

  modport master (
    output mode, in_valid, y_in, cb_in, cr_in,
    output out_ready, sat_clr,
    input  in_ready, out_valid,
    input  r_out, g_out, b_out, sat_cnt
  );
endinterface

// File: rtl/ycbcr_to_rgb_pipe.sv
// 3-stage fixed-point YCbCr->RGB converter, JPEG/BT.601 select.
// Ports: clk, rst (sync, high), bus (slave: pixel in/out, sat count).
module ycbcr_to_rgb_pipe #(
  parameter int DATA_W = 8,
  parameter int FRAC_W = 14,
  parameter int CNT_W  = 16
) (
  input logic clk,
  input logic rst,
  ycbcr_to_rgb_pipe_if.slave bus
);
  localparam int XW = DATA_W + 1;
  localparam int CW = FRAC_W + 3;
  localparam int PW = XW + CW;
  localparam int SW = PW + 2;

  // Rescale a Q2.14 coefficient to Q2.FRAC_W, round to nearest.
  function automatic longint kscale(input longint k14);
    return ((k14 <<< FRAC_W) + 64'sd8192) >>> 14;
  endfunction

  localparam logic signed [CW-1:0] KY0  = CW'(kscale(16384));
  localparam logic signed [CW-1:0] KRV0 = CW'(kscale(22971));
  localparam logic signed [CW-1:0] KGU0 = CW'(kscale(5638));
  localparam logic signed [CW-1:0] KGV0 = CW'(kscale(11700));
  localparam logic signed [CW-1:0] KBU0 = CW'(kscale(29032));
  localparam logic signed [CW-1:0] KY1  = CW'(kscale(19077));
  localparam logic signed [CW-1:0] KRV1 = CW'(kscale(26149));
  localparam logic signed [CW-1:0] KGU1 = CW'(kscale(6419));
  localparam logic signed [CW-1:0] KGV1 = CW'(kscale(13320));
  localparam logic signed [CW-1:0] KBU1 = CW'(kscale(33050));

  localparam logic signed [XW-1:0] YOFF =
    XW'(longint'(16) << (DATA_W - 8));
  localparam logic signed [XW-1:0] HALF =
    XW'(longint'(1) << (DATA_W - 1));
  localparam logic signed [SW-1:0] RND =
    SW'(longint'(1) << (FRAC_W - 1));
  localparam logic signed [SW-1:0] MAXV =
    SW'((longint'(1) << DATA_W) - 1);

  logic ov_q;
  logic en;

  // Whole pipe moves in lockstep; only a blocked output stalls it.
  assign en          = !ov_q || bus.out_ready;
  assign bus.in_ready = en;

  // Stage 1: offset removal
  logic                 v1_q, m1_q;
  logic signed [XW-1:0] yd_q, cbd_q, crd_q;
  logic signed [XW-1:0] yd_d, cbd_d, crd_d;

  always_comb begin
    yd_d  = $signed({1'b0, bus.y_in});
    if (bus.mode) yd_d = yd_d - YOFF;
    cbd_d = $signed({1'b0, bus.cb_in}) - HALF;
    crd_d = $signed({1'b0, bus.cr_in}) - HALF;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q <= 1'b0;
    end else if (en) begin
      v1_q  <= bus.in_valid;
      m1_q  <= bus.mode;
      yd_q  <= yd_d;
      cbd_q <= cbd_d;
      crd_q <= crd_d;
    end
  end

  // Stage 2: coefficient products
  logic                 v2_q;
  logic signed [CW-1:0] ky, krv, kgu, kgv, kbu;
  logic signed [PW-1:0] py_q, prv_q, pgu_q, pgv_q, pbu_q;

  always_comb begin
    if (m1_q) begin
      ky = KY1; krv = KRV1; kgu = KGU1;
      kgv = KGV1; kbu = KBU1;
    end else begin
      ky = KY0; krv = KRV0; kgu = KGU0;
      kgv = KGV0; kbu = KBU0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v2_q <= 1'b0;
    end else if (en) begin
      v2_q  <= v1_q;
      py_q  <= PW'(yd_q)  * PW'(ky);
      prv_q <= PW'(crd_q) * PW'(krv);
      pgu_q <= PW'(cbd_q) * PW'(kgu);
      pgv_q <= PW'(crd_q) * PW'(kgv);
      pbu_q <= PW'(cbd_q) * PW'(kbu);
    end
  end

  // Stage 3: sum, round half up, clamp
  logic signed [SW-1:0] r_s, g_s, b_s;
  logic [DATA_W:0]      r_c, g_c, b_c;

  // Returns {clamped, value}.
  function automatic logic [DATA_W:0] clamp(
    input logic signed [SW-1:0] v
  );
    if (v < 0)    return {1'b1, {DATA_W{1'b0}}};
    if (v > MAXV) return {1'b1, {DATA_W{1'b1}}};
    return {1'b0, v[DATA_W-1:0]};
  endfunction

  always_comb begin
    r_s = (SW'(py_q) + SW'(prv_q) + RND) >>> FRAC_W;
    g_s = (SW'(py_q) - SW'(pgu_q) - SW'(pgv_q) + RND)
          >>> FRAC_W;
    b_s = (SW'(py_q) + SW'(pbu_q) + RND) >>> FRAC_W;
    r_c = clamp(r_s);
    g_c = clamp(g_s);
    b_c = clamp(b_s);
  end

  logic [DATA_W-1:0] r_q, g_q, b_q;
  logic              sat3_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ov_q   <= 1'b0;
      r_q    <= '0;
      g_q    <= '0;
      b_q    <= '0;
      sat3_q <= 1'b0;
    end else if (en) begin
      ov_q   <= v2_q;
      r_q    <= r_c[DATA_W-1:0];
      g_q    <= g_c[DATA_W-1:0];
      b_q    <= b_c[DATA_W-1:0];
      sat3_q <= r_c[DATA_W] | g_c[DATA_W] | b_c[DATA_W];
    end
  end

  // Saturation counter: clear wins, sticks at all-ones.
  logic [CNT_W-1:0] sat_cnt_q, sat_cnt_d;

  always_comb begin
    sat_cnt_d = sat_cnt_q;
    if (bus.sat_clr)
      sat_cnt_d = '0;
    else if (ov_q && bus.out_ready && sat3_q
             && sat_cnt_q != {CNT_W{1'b1}})
      sat_cnt_d = sat_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) sat_cnt_q <= '0;
    else     sat_cnt_q <= sat_cnt_d;
  end

  assign bus.out_valid = ov_q;
  assign bus.r_out     = r_q;
  assign bus.g_out     = g_q;
  assign bus.b_out     = b_q;
  assign bus.sat_cnt   = sat_cnt_q;
endmodule

// File: tb/tb_ycbcr_to_rgb_pipe.sv
// Random + directed bench for ycbcr_to_rgb_pipe.
// Scoreboard against an arithmetic colour-conversion model.
module tb_ycbcr_to_rgb_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ycbcr_to_rgb_pipe_if #(.DATA_W(8), .CNT_W(16)) bus ();
  ycbcr_to_rgb_pipe_if #(.DATA_W(8), .CNT_W(2))  bus2 ();

  ycbcr_to_rgb_pipe #(
    .DATA_W(8), .FRAC_W(14), .CNT_W(16)
  ) u_dut (.clk(clk), .rst(rst), .bus(bus));

  ycbcr_to_rgb_pipe #(
    .DATA_W(8), .FRAC_W(14), .CNT_W(2)
  ) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));

  int n_chk  = 0;
  int n_pass = 0;
  int n_out  = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  tag, got, exp);
  endtask

  function automatic longint div_rnd(input longint v);
    longint t;
    t = v + 8192;
    if (t >= 0) return t / 16384;
    return -((-t + 16383) / 16384);
  endfunction

  function automatic int clip(input longint v, inout bit s);
    if (v < 0)   begin s = 1; return 0;   end
    if (v > 255) begin s = 1; return 255; end
    return int'(v);
  endfunction

  // Returns {sat, r, g, b}.
  function automatic logic [24:0] ref_px(input logic m,
    input int y, input int cb, input int cr);
    longint yd, cbd, crd, ky, krv, kgu, kgv, kbu;
    int r, g, b;
    bit s;
    s   = 0;
    yd  = y - (m ? 16 : 0);
    cbd = cb - 128;
    crd = cr - 128;
    ky  = m ? 19077 : 16384;
    krv = m ? 26149 : 22971;
    kgu = m ? 6419  : 5638;
    kgv = m ? 13320 : 11700;
    kbu = m ? 33050 : 29032;
    r = clip(div_rnd(ky*yd + krv*crd), s);
    g = clip(div_rnd(ky*yd - kgu*cbd - kgv*crd), s);
    b = clip(div_rnd(ky*yd + kbu*cbd), s);
    return {s, r[7:0], g[7:0], b[7:0]};
  endfunction

  logic [24:0] q[$];
  logic [15:0] exp_sat = 0;
  logic        hold_v = 0;
  logic [23:0] hold_rgb;

  always @(negedge clk) begin
    logic [24:0] e;
    logic [23:0] rgb;
    rgb = {bus.r_out, bus.g_out, bus.b_out};
    if (rst) begin
      q.delete();
      exp_sat = 0;
      hold_v  = 0;
    end else begin
      chk("sat_cnt", 64'(bus.sat_cnt), 64'(exp_sat));
      if (hold_v) begin
        chk("hold_valid", 64'(bus.out_valid), 64'd1);
        chk("hold_rgb", 64'(rgb), 64'(hold_rgb));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          chk("stale_px", 64'd1, 64'd0);
        end else begin
          e = q.pop_front();
          chk("rgb", 64'(rgb), 64'(e[23:0]));
          if (e[24] && exp_sat != 16'hffff) exp_sat++;
          n_out++;
        end
      end
      if (bus.sat_clr) exp_sat = 0;
      hold_v   = bus.out_valid && !bus.out_ready;
      hold_rgb = rgb;
      if (bus.in_valid && bus.in_ready)
        q.push_back(ref_px(bus.mode, int'(bus.y_in),
                           int'(bus.cb_in), int'(bus.cr_in)));
    end
  end

  // Call at posedge+1; returns at posedge+1 after the transfer.
  task automatic drive_px(input logic m, input logic [7:0] y,
                          input logic [7:0] cb,
                          input logic [7:0] cr);
    int   n;
    logic rdy;
    n = 0;
    bus.mode  = m;
    bus.y_in  = y;
    bus.cb_in = cb;
    bus.cr_in = cr;
    bus.in_valid = 1'b1;
    do begin
      @(negedge clk);
      rdy = bus.in_ready;
      @(posedge clk);
      n++;
    end while (!rdy && n < 200);
    if (!rdy) chk("in_timeout", 64'd0, 64'd1);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic lat_px(input string tag, input logic m,
    input logic [7:0] y, input logic [7:0] cb,
    input logic [7:0] cr, input logic [23:0] exp_rgb);
    int lat;
    drive_px(m, y, cb, cr);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.out_valid && lat < 20);
    chk({tag, "_lat"}, 64'(lat), 64'd3);
    chk({tag, "_rgb"},
        64'({bus.r_out, bus.g_out, bus.b_out}), 64'(exp_rgb));
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    chk("drain", 64'(q.size()), 64'd0);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1);
  end

  initial begin
    int n, n0;
    bus.mode = 0; bus.in_valid = 0;
    bus.y_in = 0; bus.cb_in = 0; bus.cr_in = 0;
    bus.out_ready = 1; bus.sat_clr = 0;
    bus2.mode = 0; bus2.in_valid = 0;
    bus2.y_in = 8'd255; bus2.cb_in = 8'd128;
    bus2.cr_in = 8'd255;
    bus2.out_ready = 1; bus2.sat_clr = 0;

    repeat (3) @(posedge clk);
    #1 rst = 0;
    chk("rst_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_rgb",
        64'({bus.r_out, bus.g_out, bus.b_out}), 64'd0);
    chk("rst_sat", 64'(bus.sat_cnt), 64'd0);
    chk("rst_ready", 64'(bus.in_ready), 64'd1);

    lat_px("grey", 0, 8'd128, 8'd128, 8'd128, 24'h808080);
    chk("grey_sat", 64'(bus.sat_cnt), 64'd0);
    lat_px("clampR", 0, 8'd0, 8'd128, 8'd0, 24'h005B00);
    chk("clampR_sat", 64'(bus.sat_cnt), 64'd1);

    // Limited-range black then white, back to back
    drive_px(1, 8'd16, 8'd128, 8'd128);
    drive_px(1, 8'd235, 8'd128, 8'd128);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.out_valid && n < 20);
    chk("black",
        64'({bus.r_out, bus.g_out, bus.b_out}), 64'd0);
    @(negedge clk);
    chk("white_valid", 64'(bus.out_valid), 64'd1);
    chk("white",
        64'({bus.r_out, bus.g_out, bus.b_out}),
        64'hFFFFFF);
    @(posedge clk);
    #1;
    chk("bt601_sat", 64'(bus.sat_cnt), 64'd1);

    // 8-pixel stream with a 5-cycle downstream stall
    n0 = n_out;
    fork
      begin
        for (int i = 0; i < 8; i++)
          drive_px(1'($urandom_range(0, 1)), 8'($urandom),
                   8'($urandom), 8'($urandom));
      end
      begin
        repeat (4) @(posedge clk);
        #1 bus.out_ready = 0;
        repeat (5) begin
          @(negedge clk);
          chk("stall_ready", 64'(bus.in_ready), 64'd0);
        end
        @(posedge clk);
        #1 bus.out_ready = 1;
      end
    join
    drain();
    chk("stall_count", 64'(n_out - n0), 64'd8);

    // Reset with two pixels in flight
    drive_px(0, 8'd255, 8'd128, 8'd255);
    drive_px(0, 8'd0, 8'd128, 8'd0);
    rst = 1;
    @(posedge clk);
    #1 rst = 0;
    chk("inrst_valid", 64'(bus.out_valid), 64'd0);
    chk("inrst_sat", 64'(bus.sat_cnt), 64'd0);
    repeat (6) begin
      @(negedge clk);
      chk("no_stale", 64'(bus.out_valid), 64'd0);
    end
    @(posedge clk);
    #1;
    lat_px("post_rst", 0, 8'd128, 8'd128, 8'd128,
           24'h808080);

    // Random traffic, random back-pressure
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
          drive_px(1'($urandom_range(0, 1)), 8'($urandom),
                   8'($urandom), 8'($urandom));
        end
      end
      begin
        repeat (600) begin
          @(posedge clk);
          #1 bus.out_ready = ($urandom_range(0, 3) != 0);
        end
        bus.out_ready = 1;
      end
    join
    drain();

    // 2-bit counter: sticks at 3, clear beats increment
    bus2.in_valid = 1;
    repeat (5) @(posedge clk);
    #1 bus2.in_valid = 0;
    repeat (5) @(posedge clk);
    #1;
    chk("sat_stick", 64'(bus2.sat_cnt), 64'd3);
    bus2.in_valid = 1;
    @(posedge clk);
    #1 bus2.in_valid = 0;
    n = 0;
    while (!bus2.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("clr_px_valid", 64'(bus2.out_valid), 64'd1);
    bus2.sat_clr = 1;
    @(posedge clk);
    #1 bus2.sat_clr = 0;
    chk("sat_clr", 64'(bus2.sat_cnt), 64'd0);
    chk("clr_xfer", 64'(bus2.out_valid), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
